// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Constants and types shared by the 64-point FFT datapath blocks.
//   - FFT_N / FFT_LOG2N : frame length and its log2
//   - CPLX_W / HALF_W   : packed complex word width, width of each half
//   - RE_* / IM_*       : bit positions of the real and imaginary fields
//                         inside a packed word {real, imag}
//   - reorder_state_e   : FILL / DRAIN state encoding of the output buffer
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int FFT_N     = 64;
   localparam int FFT_LOG2N = 6;
   localparam int CPLX_W    = 32;
   localparam int HALF_W    = 16;

   localparam int RE_MSB = CPLX_W - 1;
   localparam int RE_LSB = HALF_W;
   localparam int IM_MSB = HALF_W - 1;
   localparam int IM_LSB = 0;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } reorder_state_e;

endpackage

// File: rtl/bitrev_addr.sv
// ---------------------------------------------------------------------------
// bitrev_addr
//   Purely combinational bit reversal of an ADDR_W-bit address.
//   Ports:
//     addr_i : input address
//     addr_o : addr_i with bit order reversed (bit 0 <-> bit ADDR_W-1)
// ---------------------------------------------------------------------------
module bitrev_addr #(
   parameter int ADDR_W = 6
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [ADDR_W-1:0] addr_o
);

   always_comb begin
      addr_o = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         addr_o[i] = addr_i[ADDR_W-1-i];
      end
   end

endmodule

// File: rtl/fft_output_reorder.sv
// ---------------------------------------------------------------------------
// fft_output_reorder
//   Single-bank frame buffer behind the FFT output scaler. Collects one frame
//   of N = 2**ADDR_W packed complex samples (arriving bit-reversed) and then
//   streams it out in natural bin order. The bank alternates FILL -> DRAIN.
//
//   Handshakes: a beat moves on a channel in any cycle where its valid and
//   ready are both high at the rising edge. In_Ready and Out_Valid depend on
//   state only, never on the other channel's inputs, so there is no
//   combinational path from a valid to a ready.
//
//   Ports:
//     Clk, Rst_n          : clock, asynchronous active-low reset
//     Clear               : synchronous abort back to an empty FILL
//     In_Data/Valid/Last  : scaled samples from upstream, Last marks frame end
//     In_Ready            : high in FILL
//     Out_Data/Index/Last : natural-order sample, its bin number, last-bin flag
//     Out_Valid           : high in DRAIN
//     Out_Ready           : downstream accepts
//     Frame_Err           : sticky flag, In_Last seen on a non-final sample
//     Dbg_State           : current FSM state (0 = FILL, 1 = DRAIN)
// ---------------------------------------------------------------------------
module fft_output_reorder
   import fft_pkg::*;
#(
   parameter int DATA_W = CPLX_W,
   parameter int ADDR_W = FFT_LOG2N,
   parameter int BITREV = 1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Clear,
   input  logic [DATA_W-1:0] In_Data,
   input  logic              In_Valid,
   input  logic              In_Last,
   output logic              In_Ready,
   output logic [DATA_W-1:0] Out_Data,
   output logic [ADDR_W-1:0] Out_Index,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic              Out_Last,
   output logic              Frame_Err,
   output logic              Dbg_State
);

   localparam int              N        = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   reorder_state_e    state_q;
   logic [ADDR_W-1:0] wr_cnt_q;
   logic [ADDR_W-1:0] rd_cnt_q;
   logic              frame_err_q;
   logic [DATA_W-1:0] mem_q [N];

   logic [ADDR_W-1:0] rev_addr;
   logic [ADDR_W-1:0] wr_addr;

   bitrev_addr #(.ADDR_W(ADDR_W)) u_bitrev (
      .addr_i (wr_cnt_q),
      .addr_o (rev_addr)
   );

   // Scattering writes to bitrev(count) lets the read side walk the memory
   // linearly; with BITREV=0 the buffer just delays a frame in order.
   assign wr_addr = (BITREV != 0) ? rev_addr : wr_cnt_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= FILL;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
         end
      end else if (Clear) begin
         // Clear wins over any same-cycle beat; memory contents are kept.
         state_q     <= FILL;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               if (In_Valid) begin
                  mem_q[wr_addr] <= In_Data;
                  wr_cnt_q       <= wr_cnt_q + ONE;
                  // Frame length is fixed at N; a stray In_Last is only flagged.
                  if (In_Last && (wr_cnt_q != LAST_IDX)) begin
                     frame_err_q <= 1'b1;
                  end
                  if (wr_cnt_q == LAST_IDX) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (Out_Ready) begin
                  rd_cnt_q <= rd_cnt_q + ONE;
                  if (rd_cnt_q == LAST_IDX) begin
                     state_q <= FILL;
                  end
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign In_Ready  = (state_q == FILL);
   assign Out_Valid = (state_q == DRAIN);
   assign Out_Data  = (state_q == DRAIN) ? mem_q[rd_cnt_q] : '0;
   assign Out_Index = (state_q == DRAIN) ? rd_cnt_q : '0;
   assign Out_Last  = (state_q == DRAIN) && (rd_cnt_q == LAST_IDX);
   assign Frame_Err = frame_err_q;
   assign Dbg_State = state_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_output_reorder
//   Instance a: BITREV=1 (reordering), instance b: BITREV=0 (pass-through).
//   Expected output words are queued as samples are accepted and compared
//   against each output beat.
// ---------------------------------------------------------------------------
module tb_fft_output_reorder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance a (bit-reversed write) ----------------
   logic        a_clear = 1'b0;
   logic [31:0] a_in_data = '0;
   logic        a_in_valid = 1'b0;
   logic        a_in_last = 1'b0;
   logic        a_in_ready;
   logic [31:0] a_out_data;
   logic [5:0]  a_out_index;
   logic        a_out_valid;
   logic        a_out_ready = 1'b1;
   logic        a_out_last;
   logic        a_frame_err;
   logic        a_dbg_state;

   fft_output_reorder #(.DATA_W(32), .ADDR_W(6), .BITREV(1)) dut_a (
      .Clk       (clk),
      .Rst_n     (rst_n),
      .Clear     (a_clear),
      .In_Data   (a_in_data),
      .In_Valid  (a_in_valid),
      .In_Last   (a_in_last),
      .In_Ready  (a_in_ready),
      .Out_Data  (a_out_data),
      .Out_Index (a_out_index),
      .Out_Valid (a_out_valid),
      .Out_Ready (a_out_ready),
      .Out_Last  (a_out_last),
      .Frame_Err (a_frame_err),
      .Dbg_State (a_dbg_state)
   );

   // ---------------- instance b (natural-order write) ----------------
   logic        b_clear = 1'b0;
   logic [31:0] b_in_data = '0;
   logic        b_in_valid = 1'b0;
   logic        b_in_last = 1'b0;
   logic        b_in_ready;
   logic [31:0] b_out_data;
   logic [5:0]  b_out_index;
   logic        b_out_valid;
   logic        b_out_ready = 1'b1;
   logic        b_out_last;
   logic        b_frame_err;
   logic        b_dbg_state;

   fft_output_reorder #(.DATA_W(32), .ADDR_W(6), .BITREV(0)) dut_b (
      .Clk       (clk),
      .Rst_n     (rst_n),
      .Clear     (b_clear),
      .In_Data   (b_in_data),
      .In_Valid  (b_in_valid),
      .In_Last   (b_in_last),
      .In_Ready  (b_in_ready),
      .Out_Data  (b_out_data),
      .Out_Index (b_out_index),
      .Out_Valid (b_out_valid),
      .Out_Ready (b_out_ready),
      .Out_Last  (b_out_last),
      .Frame_Err (b_frame_err),
      .Dbg_State (b_dbg_state)
   );

   // ---------------- scoreboards ----------------
   logic [31:0] a_exp_q[$];
   logic [31:0] b_exp_q[$];
   logic [31:0] a_model [64];
   logic [5:0]  a_wr = '0;
   logic [5:0]  a_bin = '0;
   logic [5:0]  b_bin = '0;

   function automatic logic [5:0] bitrev6(input logic [5:0] v);
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) r[i] = v[5-i];
      return r;
   endfunction

   // Bench model of one accepted write into instance a.
   task automatic a_accept(input logic [31:0] d);
      a_model[bitrev6(a_wr)] = d;
      if (a_wr == 6'd63) begin
         for (int i = 0; i < 64; i++) a_exp_q.push_back(a_model[i]);
      end
      a_wr = a_wr + 6'd1;
   endtask

   // Output monitors: every beat is popped and compared.
   always @(negedge clk) begin
      logic [31:0] exp_d;
      #1;
      if (rst_n && a_out_valid && a_out_ready) begin
         checks++;
         if (a_exp_q.size() == 0) begin
            errors++;
            $display("FAIL a_extra_beat idx=%0d data=%h expected no beat", a_out_index, a_out_data);
         end else begin
            exp_d = a_exp_q.pop_front();
            if (a_out_data !== exp_d || a_out_index !== a_bin || a_out_last !== (a_bin == 6'd63)) begin
               errors++;
               $display("FAIL a_beat got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                        a_out_data, a_out_index, a_out_last, exp_d, a_bin, (a_bin == 6'd63));
            end
         end
         a_bin = a_bin + 6'd1;
      end
      if (rst_n && b_out_valid && b_out_ready) begin
         checks++;
         if (b_exp_q.size() == 0) begin
            errors++;
            $display("FAIL b_extra_beat idx=%0d data=%h expected no beat", b_out_index, b_out_data);
         end else begin
            exp_d = b_exp_q.pop_front();
            if (b_out_data !== exp_d || b_out_index !== b_bin || b_out_last !== (b_bin == 6'd63)) begin
               errors++;
               $display("FAIL b_beat got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                        b_out_data, b_out_index, b_out_last, exp_d, b_bin, (b_bin == 6'd63));
            end
         end
         b_bin = b_bin + 6'd1;
      end
   end

   // ---------------- drivers ----------------
   // Present one sample to instance a until it is accepted (inputs left driven).
   task automatic a_send(input logic [31:0] d, input logic last);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         a_in_valid = 1'b1;
         a_in_data  = d;
         a_in_last  = last;
         if (a_in_ready) begin
            a_accept(d);
            return;
         end
         n++;
         if (n > 300) begin
            errors++;
            checks++;
            $display("FAIL a_send_timeout in_ready=%b expected 1", a_in_ready);
            return;
         end
      end
   endtask

   // Let instance a drain completely with Out_Ready high.
   task automatic a_drain_wait();
      int n;
      n = 0;
      a_out_ready = 1'b1;
      forever begin
         @(negedge clk);
         a_in_valid = 1'b0;
         a_in_last  = 1'b0;
         if (a_in_ready && a_exp_q.size() == 0) return;
         n++;
         if (n > 300) begin
            errors++;
            checks++;
            $display("FAIL a_drain_timeout pending=%0d expected 0", a_exp_q.size());
            return;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 32'h0 ||
          a_out_index !== 6'd0 || a_out_last !== 1'b0 || a_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_a rdy=%b vld=%b data=%h idx=%0d last=%b err=%b expected 1 0 0 0 0 0",
                  a_in_ready, a_out_valid, a_out_data, a_out_index, a_out_last, a_frame_err);
      end
      checks++;
      if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 32'h0 || b_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_b rdy=%b vld=%b data=%h err=%b expected 1 0 0 0",
                  b_in_ready, b_out_valid, b_out_data, b_frame_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (a_dbg_state !== 1'b0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release state=%b rdy=%b vld=%b expected 0 1 0", a_dbg_state, a_in_ready, a_out_valid);
      end
   endtask

   task automatic test_ordering();
      logic [15:0] k16;
      int n;
      a_out_ready = 1'b1;
      for (int k = 0; k < 64; k++) begin
         k16 = 16'(k);
         a_send({k16, k16}, k == 63);
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_index !== 6'd0 || a_out_data !== 32'h0) begin
         errors++;
         $display("FAIL order_latency vld=%b idx=%0d data=%h expected 1 0 00000000", a_out_valid, a_out_index, a_out_data);
      end
      n = 0;
      forever begin
         if (a_out_valid && a_out_index == 6'd1) begin
            checks++;
            if (a_out_data !== 32'h0020_0020) begin
               errors++;
               $display("FAIL order_bin1 got %h expected 00200020", a_out_data);
            end
         end
         if (a_out_valid && a_out_index == 6'd2) begin
            checks++;
            if (a_out_data !== 32'h0010_0010) begin
               errors++;
               $display("FAIL order_bin2 got %h expected 00100010", a_out_data);
            end
         end
         if (a_out_valid && a_out_index == 6'd63) begin
            checks++;
            if (a_out_data !== 32'h003F_003F || a_out_last !== 1'b1 || a_frame_err !== 1'b0) begin
               errors++;
               $display("FAIL order_bin63 data=%h last=%b err=%b expected 003f003f 1 0", a_out_data, a_out_last, a_frame_err);
            end
         end
         if (a_in_ready && a_exp_q.size() == 0) break;
         n++;
         if (n > 200) begin
            errors++;
            checks++;
            $display("FAIL order_timeout pending=%0d expected 0", a_exp_q.size());
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] cap_d;
      logic [5:0]  cap_i;
      logic        cap_l;
      logic        stalled;
      int n;
      for (int k = 0; k < 64; k++) a_send($urandom, k == 63);
      stalled = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         a_in_valid = 1'b0;
         a_in_last  = 1'b0;
         if (a_out_valid && a_out_index == 6'd10 && !stalled) begin
            stalled     = 1'b1;
            cap_d       = a_out_data;
            cap_i       = a_out_index;
            cap_l       = a_out_last;
            a_out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               checks++;
               if (a_out_valid !== 1'b1 || a_out_data !== cap_d || a_out_index !== cap_i || a_out_last !== cap_l) begin
                  errors++;
                  $display("FAIL stall_hold vld=%b data=%h idx=%0d last=%b expected 1 %h %0d %b",
                           a_out_valid, a_out_data, a_out_index, a_out_last, cap_d, cap_i, cap_l);
               end
            end
            a_out_ready = 1'b1;
         end
         if (a_in_ready && a_exp_q.size() == 0) break;
         n++;
         if (n > 300) begin
            errors++;
            checks++;
            $display("FAIL stall_timeout pending=%0d expected 0", a_exp_q.size());
            break;
         end
      end
      checks++;
      if (stalled !== 1'b1) begin
         errors++;
         $display("FAIL stall_reached stalled=%b expected 1", stalled);
      end
   endtask

   task automatic test_gaps_and_drain_block();
      logic [31:0] sentinel;
      int n;
      sentinel = 32'hDEAD_0001;
      for (int k = 0; k < 64; k++) begin
         a_send($urandom, k == 63);
         if (k < 63) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            if (k == 5) begin
               checks++;
               if (a_out_data !== 32'h0 || a_out_index !== 6'd0 || a_out_last !== 1'b0 || a_out_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL fill_outputs data=%h idx=%0d last=%b vld=%b expected 0 0 0 0",
                           a_out_data, a_out_index, a_out_last, a_out_valid);
               end
            end
         end
      end
      // Hold In_Valid through the whole drain; only the first FILL cycle may take it.
      n = 0;
      a_out_ready = 1'b1;
      forever begin
         @(negedge clk);
         a_in_valid = 1'b1;
         a_in_data  = sentinel;
         a_in_last  = 1'b0;
         checks++;
         if (a_in_ready === a_out_valid) begin
            errors++;
            $display("FAIL drain_block rdy=%b vld=%b expected complementary", a_in_ready, a_out_valid);
         end
         if (a_in_ready) begin
            checks++;
            if (a_exp_q.size() != 0) begin
               errors++;
               $display("FAIL drain_block_early pending=%0d expected 0", a_exp_q.size());
            end
            a_accept(sentinel);
            break;
         end
         n++;
         if (n > 200) begin
            errors++;
            checks++;
            $display("FAIL drain_block_timeout rdy=%b expected 1", a_in_ready);
            break;
         end
      end
      for (int k = 1; k < 64; k++) a_send($urandom, k == 63);
      a_drain_wait();
      checks++;
      if (a_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL gaps_frame_err got %b expected 0", a_frame_err);
      end
   endtask

   task automatic test_misalign_and_clear();
      for (int k = 0; k < 40; k++) a_send($urandom, 1'b0);
      a_send($urandom, 1'b1);   // 41st sample, wr_cnt = 40
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      checks++;
      if (a_frame_err !== 1'b1) begin
         errors++;
         $display("FAIL misalign_flag got %b expected 1", a_frame_err);
      end
      for (int k = 41; k < 64; k++) begin
         checks++;
         if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_early_drain at sample %0d vld=%b expected 0", k, a_out_valid);
         end
         a_send($urandom, 1'b0);
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_index !== 6'd0) begin
         errors++;
         $display("FAIL misalign_drain_start vld=%b idx=%0d expected 1 0", a_out_valid, a_out_index);
      end
      a_drain_wait();
      checks++;
      if (a_frame_err !== 1'b1) begin
         errors++;
         $display("FAIL misalign_sticky got %b expected 1", a_frame_err);
      end
      // Partial frame, then Clear together with a sample that must be discarded.
      for (int k = 0; k < 10; k++) a_send($urandom, 1'b0);
      @(negedge clk);
      a_clear    = 1'b1;
      a_in_valid = 1'b1;
      a_in_data  = 32'hBAD0_BAD0;
      @(negedge clk);
      a_clear    = 1'b0;
      a_in_valid = 1'b0;
      a_wr       = 6'd0;
      checks++;
      if (a_frame_err !== 1'b0 || a_dbg_state !== 1'b0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_state err=%b state=%b rdy=%b vld=%b expected 0 0 1 0",
                  a_frame_err, a_dbg_state, a_in_ready, a_out_valid);
      end
      // Full frame with no In_Last at all: counters restarted, no error.
      for (int k = 0; k < 64; k++) a_send($urandom, 1'b0);
      a_drain_wait();
      checks++;
      if (a_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL clear_no_last_err got %b expected 0", a_frame_err);
      end
   endtask

   task automatic test_reset_mid_drain();
      int n;
      for (int k = 0; k < 64; k++) a_send($urandom, k == 63);
      n = 0;
      forever begin
         @(negedge clk);
         a_in_valid = 1'b0;
         a_in_last  = 1'b0;
         if (a_out_valid && a_out_index == 6'd30) break;
         n++;
         if (n > 200) begin
            errors++;
            checks++;
            $display("FAIL rst_mid_reach idx=%0d expected 30", a_out_index);
            break;
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_in_ready !== 1'b1 || a_out_index !== 6'd0) begin
         errors++;
         $display("FAIL rst_async vld=%b data=%h rdy=%b idx=%0d expected 0 0 1 0",
                  a_out_valid, a_out_data, a_in_ready, a_out_index);
      end
      a_exp_q.delete();
      b_exp_q.delete();
      a_bin = 6'd0;
      b_bin = 6'd0;
      a_wr  = 6'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1 || a_dbg_state !== 1'b0) begin
         errors++;
         $display("FAIL rst_release rdy=%b state=%b expected 1 0", a_in_ready, a_dbg_state);
      end
      for (int k = 0; k < 64; k++) a_send($urandom, k == 63);
      a_drain_wait();
   endtask

   task automatic test_back_to_back();
      logic [31:0] smp [128];
      int idx, t1, t2;
      logic prev_v;
      for (int i = 0; i < 128; i++) smp[i] = $urandom;
      b_out_ready = 1'b1;
      idx = 0;
      t1 = -1;
      t2 = -1;
      prev_v = 1'b0;
      for (int n = 0; n < 700; n++) begin
         @(negedge clk);
         if (b_out_valid && !prev_v) begin
            if (t1 < 0) t1 = cyc;
            else if (t2 < 0) t2 = cyc;
         end
         prev_v = b_out_valid;
         if (idx < 128) begin
            b_in_valid = 1'b1;
            b_in_data  = smp[idx];
            b_in_last  = ((idx % 64) == 63);
            if (b_in_ready) begin
               b_exp_q.push_back(smp[idx]);
               idx++;
            end
         end else begin
            b_in_valid = 1'b0;
            b_in_last  = 1'b0;
            if (b_exp_q.size() == 0 && b_in_ready) break;
         end
      end
      checks++;
      if (idx != 128 || b_exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_complete accepted=%0d pending=%0d expected 128 0", idx, b_exp_q.size());
      end
      checks++;
      if (t1 < 0 || t2 < 0 || (t2 - t1) != 128) begin
         errors++;
         $display("FAIL b2b_period t1=%0d t2=%0d gap=%0d expected 128", t1, t2, t2 - t1);
      end
      checks++;
      if (b_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_frame_err got %b expected 0", b_frame_err);
      end
   endtask

   initial begin
      test_reset();
      test_ordering();
      test_backpressure();
      test_gaps_and_drain_block();
      test_misalign_and_clear();
      test_reset_mid_drain();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d expected bench to finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Output-side frame buffer placed directly downstream of the output scaling stage of the 64-point FFT processor.
- Collects one 64-sample frame of packed complex results ({real[31:16], imag[15:0]}), which arrives in bit-reversed order.
- Streams the frame out in natural order (bin 0..63) over a valid/ready handshake.
- Single-bank design: the buffer alternates between filling and draining.

Parameters:
DATA_W, 32, packed complex width (real in upper half, imag in lower half)
ADDR_W, 6, log2 of frame length (N = 2**ADDR_W = 64)
BITREV, 1, 1 = write address is the bit-reversed input count; 0 = natural-order write (pass-through ordering)

Ports:
Clk  input  1  system clock, all state on rising edge
Rst_n  input  1  reset, asynchronous assert, active-low
Clear  input  1  synchronous abort: return to FILL, zero counters, clear Frame_Err
In_Data  input  DATA_W  scaled FFT sample
In_Valid  input  1  In_Data valid
In_Last  input  1  upstream marks last sample of frame
In_Ready  output  1  buffer accepts a sample this cycle
Out_Data  output  DATA_W  natural-order sample
Out_Index  output  ADDR_W  bin number of Out_Data
Out_Valid  output  1  Out_Data valid
Out_Ready  input  1  downstream accepts
Out_Last  output  1  high with bin N-1
Frame_Err  output  1  sticky In_Last misalignment flag

Behaviour:
- Clock and reset: one clock (Clk); reset Rst_n is asynchronous and active-low.
- Reset values: state=FILL, wr_cnt=0, rd_cnt=0, all 64 storage words=0, Frame_Err=0.
  - Outputs after reset: In_Ready=1, Out_Valid=0, Out_Data=0, Out_Index=0, Out_Last=0.
- States: FILL, DRAIN (2-state FSM).
- FILL:
  - In_Ready=1 and Out_Valid=0.
  - Out_Data, Out_Index and Out_Last are forced to 0.
  - On In_Valid: write mem[BITREV ? bitrev(wr_cnt) : wr_cnt] <= In_Data, then wr_cnt++.
  - Accepting the sample with wr_cnt==N-1 moves to DRAIN next cycle, and wr_cnt wraps to 0.
  - In_Valid low leaves all state unchanged (gaps allowed).
- In_Last check: if In_Last is high on an accepted sample and wr_cnt!=N-1, set Frame_Err (sticky). The frame still completes at N samples; no resync.
  - If In_Last is low on the sample with wr_cnt==N-1, do not set Frame_Err.
- DRAIN:
  - In_Ready=0 and Out_Valid=1.
  - Out_Data=mem[rd_cnt], Out_Index=rd_cnt, Out_Last=(rd_cnt==N-1).
  - Read is combinational from the storage registers.
  - Transfer on Out_Valid&&Out_Ready: rd_cnt++.
  - Transfer at rd_cnt==N-1 moves to FILL next cycle, and rd_cnt wraps to 0.
  - While Out_Ready=0, Out_Data, Out_Index and Out_Last hold stable.
  - In_Valid during DRAIN is ignored; upstream must hold it.
- Latency: the first output (bin 0) is valid the cycle after the N-th input is accepted.
  - Minimum frame period is 2N = 128 cycles (no gaps, Out_Ready=1).
- Clear (synchronous) has priority over any transfer in the same cycle.
  - Effect: state=FILL, counters=0, Frame_Err=0; the memory is not cleared.
  - The transfer coinciding with Clear is discarded.
- Reset asserted mid-operation: immediate return to reset values, including the memory.
- Width rules: data is stored and forwarded unmodified. There is no arithmetic and no sign handling; this block only reorders.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=64, FFT_LOG2N=6, CPLX_W=32, HALF_W=16.
  - Real/imag field slice constants.
  - State encoding localparams FILL=1'b0, DRAIN=1'b1.
- One sub-module: bitrev_addr (parameterised ADDR_W, combinational bit reversal).
  - Reusable by the input-side reorder and the twiddle address generator.

Test Plan:
- Ordering check:
  - Stimulus: BITREV=1, Out_Ready=1; feed sample k = {k[15:0], k[15:0]} for k=0..63, In_Last on k=63.
  - Required response: bin n carries bitrev(n). Bin 1 = 0x0020_0020, bin 2 = 0x0010_0010, bin 63 = 0x003F_003F with Out_Last=1, Frame_Err=0.
  - First Out_Valid appears 1 cycle after the 64th accept.
- Backpressure:
  - Stimulus: drop Out_Ready for 5 cycles while Out_Index=10.
  - Required response: Out_Data/Out_Index/Out_Last hold; the bin sequence shows no skipped or duplicated bin.
- Input gaps and DRAIN blocking:
  - Stimulus: toggle In_Valid every other cycle during FILL; then assert In_Valid throughout DRAIN.
  - Required response: exactly 64 writes; In_Ready=0 in DRAIN; wr_cnt does not move until FILL resumes.
- Misalignment:
  - Stimulus: In_Last on the 41st sample (wr_cnt=40).
  - Required response: Frame_Err=1 the next cycle, and DRAIN still begins after 64 samples.
  - Stimulus: pulse Clear.
  - Required response: Frame_Err=0, state=FILL, In_Ready=1.
- Reset mid-drain:
  - Stimulus: assert Rst_n=0 asynchronously at Out_Index=30.
  - Required response: Out_Valid=0 and Out_Data=0 without waiting for a clock edge. After release, In_Ready=1 and the next frame starts at bin 0.
- Pass-through and back-to-back frames:
  - Stimulus: BITREV=0; send two back-to-back frames.
  - Required response: outputs come in input order; frame 2's first bin is valid exactly 128 cycles after frame 1's.
